// File: rtl/l1_sched_pkg.sv
// Shared types and sizes for the L1 trigger scheduler.
// Slot count matches the 4-bit trigger ID.
package l1_sched_pkg;

    localparam int DEPTH = 16;
    localparam int OCC_W = 5;
    localparam int CNT_W = 4;
    localparam int REM_W = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/tmr_vote.sv
// Bitwise 2-of-3 majority voter.
// Used for every triplicated register in the scheduler.
module tmr_vote #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] y
);

    assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/l1_trigger_scheduler.sv
// Expands external L1 pulses into bursts and tracks L1 bank occupancy.
// State, Remain and Occupancy are triplicated and majority voted.
module l1_trigger_scheduler
    import l1_sched_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             L1_Ext,
    input  logic [CNT_W-1:0] Trig_Cnt,
    input  logic             Read_Done,
    output logic             L1,
    output logic             L1_Reg_Full,
    output logic [OCC_W-1:0] Occupancy,
    output logic             Busy,
    output logic             Dropped,
    output logic             Ext_Ignored,
    output logic             Underflow,
    output logic             Error
);

    state_t           state_q0, state_q1, state_q2;
    logic [REM_W-1:0] rem_q0, rem_q1, rem_q2;
    logic [OCC_W-1:0] occ_q0, occ_q1, occ_q2;
    logic             err_q0, err_q1, err_q2;

    logic             st_y;
    state_t           state_v;
    logic [REM_W-1:0] rem_v;
    logic [OCC_W-1:0] occ_v;

    state_t           state_n;
    logic [REM_W-1:0] rem_n;
    logic [OCC_W-1:0] occ_n;

    logic             full;
    logic             dec;
    logic             mismatch;

    tmr_vote #(.W(1)) u_vote_state (
        .a (state_q0),
        .b (state_q1),
        .c (state_q2),
        .y (st_y)
    );

    tmr_vote #(.W(REM_W)) u_vote_rem (
        .a (rem_q0),
        .b (rem_q1),
        .c (rem_q2),
        .y (rem_v)
    );

    tmr_vote #(.W(OCC_W)) u_vote_occ (
        .a (occ_q0),
        .b (occ_q1),
        .c (occ_q2),
        .y (occ_v)
    );

    tmr_vote #(.W(1)) u_vote_err (
        .a (err_q0),
        .b (err_q1),
        .c (err_q2),
        .y (Error)
    );

    assign state_v     = state_t'(st_y);
    assign full        = (occ_v >= OCC_W'(DEPTH));
    assign Busy        = (state_v == BURST);
    assign L1          = Busy && !full;
    assign Dropped     = Busy && full;
    assign L1_Reg_Full = full;
    assign Occupancy   = occ_v;
    assign Ext_Ignored = L1_Ext && Busy;
    assign Underflow   = Read_Done && (occ_v == '0);
    assign dec         = Read_Done && (occ_v != '0);

    // Next burst state and occupancy, computed from the voted values
    always_comb begin
        state_n = state_v;
        rem_n   = rem_v;
        occ_n   = occ_v;
        unique case (state_v)
            IDLE: begin
                if (L1_Ext) begin
                    state_n = BURST;
                    rem_n   = (Trig_Cnt == '0) ? REM_W'(DEPTH)
                                               : REM_W'(Trig_Cnt);
                end
            end
            BURST: begin
                rem_n = (rem_v == '0) ? '0 : rem_v - REM_W'(1);
                if (rem_v <= REM_W'(1)) begin
                    state_n = IDLE;
                end
            end
        endcase
        if (L1 && !dec) begin
            occ_n = occ_v + OCC_W'(1);
        end else if (dec && !L1) begin
            occ_n = occ_v - OCC_W'(1);
        end
    end

    // All three copies reload from the vote so an upset heals in one edge
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q0 <= IDLE;
            state_q1 <= IDLE;
            state_q2 <= IDLE;
            rem_q0   <= '0;
            rem_q1   <= '0;
            rem_q2   <= '0;
            occ_q0   <= '0;
            occ_q1   <= '0;
            occ_q2   <= '0;
        end else begin
            state_q0 <= state_n;
            state_q1 <= state_n;
            state_q2 <= state_n;
            rem_q0   <= rem_n;
            rem_q1   <= rem_n;
            rem_q2   <= rem_n;
            occ_q0   <= occ_n;
            occ_q1   <= occ_n;
            occ_q2   <= occ_n;
        end
    end

    assign mismatch = (state_q0 != state_q1) || (state_q0 != state_q2)
                   || (rem_q0 != rem_q1) || (rem_q0 != rem_q2)
                   || (occ_q0 != occ_q1) || (occ_q0 != occ_q2);

    // Copy disagreement is sampled mid-cycle, away from the update edge
    always_ff @(negedge Clk or negedge Reset) begin
        if (!Reset) begin
            err_q0 <= 1'b0;
            err_q1 <= 1'b0;
            err_q2 <= 1'b0;
        end else begin
            err_q0 <= mismatch;
            err_q1 <= mismatch;
            err_q2 <= mismatch;
        end
    end

endmodule

// File: tb/tb_l1_trigger_scheduler.sv
// Directed self-checking bench for l1_trigger_scheduler.
// Inputs change 1 ns after the rising edge, outputs are sampled after the falling edge.
module tb_l1_trigger_scheduler;

    logic       Clk;
    logic       Reset;
    logic       L1_Ext;
    logic [3:0] Trig_Cnt;
    logic       Read_Done;
    logic       L1;
    logic       L1_Reg_Full;
    logic [4:0] Occupancy;
    logic       Busy;
    logic       Dropped;
    logic       Ext_Ignored;
    logic       Underflow;
    logic       Error;

    int checks;
    int errors;

    l1_trigger_scheduler dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .L1_Ext      (L1_Ext),
        .Trig_Cnt    (Trig_Cnt),
        .Read_Done   (Read_Done),
        .L1          (L1),
        .L1_Reg_Full (L1_Reg_Full),
        .Occupancy   (Occupancy),
        .Busy        (Busy),
        .Dropped     (Dropped),
        .Ext_Ignored (Ext_Ignored),
        .Underflow   (Underflow),
        .Error       (Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // start of a new cycle, inputs may change
    task automatic nxt();
        @(posedge Clk);
        #1;
    endtask

    // mid cycle, outputs are stable
    task automatic half();
        @(negedge Clk);
        #1;
    endtask

    task automatic do_reset();
        L1_Ext    = 1'b0;
        Read_Done = 1'b0;
        Trig_Cnt  = 4'd0;
        Reset     = 1'b0;
        nxt();
        nxt();
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        L1_Ext    = 1'b0;
        Read_Done = 1'b0;
        Trig_Cnt  = 4'd0;
        Reset     = 1'b0;
        #12;
        checks++;
        if ({L1, L1_Reg_Full, Occupancy, Busy, Dropped,
             Ext_Ignored, Underflow, Error} !== 12'd0) begin
            errors++;
            $display("FAIL reset_outputs got L1=%b Full=%b Occ=%0d Busy=%b Drop=%b Ign=%b Und=%b Err=%b want all 0",
                     L1, L1_Reg_Full, Occupancy, Busy, Dropped,
                     Ext_Ignored, Underflow, Error);
        end
        nxt();
        Reset = 1'b1;
    endtask

    task automatic test_burst4();
        do_reset();
        nxt();
        L1_Ext   = 1'b1;
        Trig_Cnt = 4'd4;
        half();
        checks++;
        if (Busy !== 1'b0 || L1 !== 1'b0) begin
            errors++;
            $display("FAIL b4_trigger_cycle got Busy=%b L1=%b want 0 0", Busy, L1);
        end
        nxt();
        L1_Ext = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            half();
            checks++;
            if (L1 !== 1'b1 || Busy !== 1'b1 || Occupancy !== 5'(i - 1)) begin
                errors++;
                $display("FAIL b4_cycle%0d got L1=%b Busy=%b Occ=%0d want 1 1 %0d",
                         i, L1, Busy, Occupancy, i - 1);
            end
            nxt();
        end
        half();
        checks++;
        if (L1 !== 1'b0 || Busy !== 1'b0 || Occupancy !== 5'd4) begin
            errors++;
            $display("FAIL b4_end got L1=%b Busy=%b Occ=%0d want 0 0 4",
                     L1, Busy, Occupancy);
        end
        nxt();
    endtask

    task automatic test_full_and_drop();
        int l1s;
        int drops;
        do_reset();
        nxt();
        L1_Ext   = 1'b1;
        Trig_Cnt = 4'd0;
        nxt();
        L1_Ext = 1'b0;
        l1s    = 0;
        for (int i = 0; i < 18; i++) begin
            half();
            if (L1 === 1'b1) l1s++;
            nxt();
        end
        half();
        checks++;
        if (l1s !== 16) begin
            errors++;
            $display("FAIL full_l1_count got %0d want 16", l1s);
        end
        checks++;
        if (Occupancy !== 5'd16 || L1_Reg_Full !== 1'b1) begin
            errors++;
            $display("FAIL full_state got Occ=%0d Full=%b want 16 1",
                     Occupancy, L1_Reg_Full);
        end
        nxt();
        L1_Ext   = 1'b1;
        Trig_Cnt = 4'd3;
        nxt();
        L1_Ext = 1'b0;
        l1s    = 0;
        drops  = 0;
        for (int i = 0; i < 5; i++) begin
            half();
            if (L1 === 1'b1) l1s++;
            if (Dropped === 1'b1) drops++;
            nxt();
        end
        checks++;
        if (drops !== 3 || l1s !== 0) begin
            errors++;
            $display("FAIL full_drop got drops=%0d l1=%0d want 3 0", drops, l1s);
        end
        half();
        checks++;
        if (Occupancy !== 5'd16 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL full_after_drop got Occ=%0d Busy=%b want 16 0",
                     Occupancy, Busy);
        end
        nxt();
    endtask

    // continues from a full bank
    task automatic test_read_in_full();
        L1_Ext   = 1'b1;
        Trig_Cnt = 4'd2;
        nxt();
        L1_Ext    = 1'b0;
        Read_Done = 1'b1;
        half();
        checks++;
        if (L1 !== 1'b0 || Dropped !== 1'b1 || Underflow !== 1'b0) begin
            errors++;
            $display("FAIL rf_first got L1=%b Drop=%b Und=%b want 0 1 0",
                     L1, Dropped, Underflow);
        end
        nxt();
        Read_Done = 1'b0;
        half();
        checks++;
        if (Occupancy !== 5'd15 || L1 !== 1'b1 || Dropped !== 1'b0) begin
            errors++;
            $display("FAIL rf_second got Occ=%0d L1=%b Drop=%b want 15 1 0",
                     Occupancy, L1, Dropped);
        end
        nxt();
        half();
        checks++;
        if (Occupancy !== 5'd16 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL rf_end got Occ=%0d Busy=%b want 16 0", Occupancy, Busy);
        end
        nxt();
    endtask

    task automatic test_both_and_underflow();
        do_reset();
        half();
        Read_Done = 1'b1;
        #1;
        checks++;
        if (Underflow !== 1'b1) begin
            errors++;
            $display("FAIL underflow_flag got %b want 1", Underflow);
        end
        nxt();
        Read_Done = 1'b0;
        half();
        checks++;
        if (Occupancy !== 5'd0 || Underflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow_occ got Occ=%0d Und=%b want 0 0",
                     Occupancy, Underflow);
        end
        nxt();
        L1_Ext   = 1'b1;
        Trig_Cnt = 4'd5;
        nxt();
        L1_Ext = 1'b0;
        for (int i = 0; i < 6; i++) nxt();
        half();
        checks++;
        if (Occupancy !== 5'd5) begin
            errors++;
            $display("FAIL both_pre got Occ=%0d want 5", Occupancy);
        end
        nxt();
        L1_Ext   = 1'b1;
        Trig_Cnt = 4'd1;
        nxt();
        L1_Ext    = 1'b0;
        Read_Done = 1'b1;
        half();
        checks++;
        if (L1 !== 1'b1) begin
            errors++;
            $display("FAIL both_l1 got %b want 1", L1);
        end
        nxt();
        Read_Done = 1'b0;
        half();
        checks++;
        if (Occupancy !== 5'd5 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL both_occ got Occ=%0d Busy=%b want 5 0", Occupancy, Busy);
        end
        nxt();
        Read_Done = 1'b1;
        nxt();
        Read_Done = 1'b0;
        half();
        checks++;
        if (Occupancy !== 5'd4) begin
            errors++;
            $display("FAIL read_only got Occ=%0d want 4", Occupancy);
        end
        nxt();
    endtask

    task automatic test_retrigger();
        int l1s;
        logic [8:0] ext_pat;
        logic [8:0] ign_exp;
        do_reset();
        nxt();
        ext_pat  = 9'b0_0001_0101;
        ign_exp  = 9'b0_0001_0100;
        l1s      = 0;
        for (int i = 0; i < 9; i++) begin
            L1_Ext   = ext_pat[i];
            Trig_Cnt = (i == 0) ? 4'd4 : 4'd2;
            half();
            if (L1 === 1'b1) l1s++;
            checks++;
            if (Ext_Ignored !== ign_exp[i]) begin
                errors++;
                $display("FAIL retrig_ignored_c%0d got %b want %b",
                         i, Ext_Ignored, ign_exp[i]);
            end
            nxt();
        end
        L1_Ext = 1'b0;
        checks++;
        if (l1s !== 4) begin
            errors++;
            $display("FAIL retrig_count got %0d want 4", l1s);
        end
    endtask

    task automatic test_seu();
        do_reset();
        nxt();
        L1_Ext   = 1'b1;
        Trig_Cnt = 4'd3;
        nxt();
        L1_Ext = 1'b0;
        for (int i = 0; i < 4; i++) nxt();
        force dut.occ_q1 = 5'd9;
        #1;
        checks++;
        if (Occupancy !== 5'd3 || Error !== 1'b0) begin
            errors++;
            $display("FAIL seu_before_fall got Occ=%0d Err=%b want 3 0",
                     Occupancy, Error);
        end
        half();
        checks++;
        if (Occupancy !== 5'd3 || Error !== 1'b1) begin
            errors++;
            $display("FAIL seu_detect got Occ=%0d Err=%b want 3 1",
                     Occupancy, Error);
        end
        release dut.occ_q1;
        nxt();
        checks++;
        if (Error !== 1'b1 || Occupancy !== 5'd3) begin
            errors++;
            $display("FAIL seu_hold got Err=%b Occ=%0d want 1 3", Error, Occupancy);
        end
        half();
        checks++;
        if (Error !== 1'b0 || Occupancy !== 5'd3) begin
            errors++;
            $display("FAIL seu_clear got Err=%b Occ=%0d want 0 3", Error, Occupancy);
        end
        nxt();
    endtask

    task automatic test_reset_mid_burst();
        int l1s;
        do_reset();
        nxt();
        L1_Ext   = 1'b1;
        Trig_Cnt = 4'd8;
        nxt();
        L1_Ext = 1'b0;
        nxt();
        #2;
        checks++;
        if (L1 !== 1'b1 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre got L1=%b Busy=%b want 1 1", L1, Busy);
        end
        Reset = 1'b0;
        #1;
        checks++;
        if ({L1, L1_Reg_Full, Occupancy, Busy, Dropped,
             Ext_Ignored, Underflow, Error} !== 12'd0) begin
            errors++;
            $display("FAIL mid_reset got L1=%b Occ=%0d Busy=%b Drop=%b Err=%b want all 0",
                     L1, Occupancy, Busy, Dropped, Error);
        end
        nxt();
        Reset = 1'b1;
        l1s   = 0;
        for (int i = 0; i < 10; i++) begin
            half();
            if (L1 === 1'b1 || Busy === 1'b1) l1s++;
            nxt();
        end
        checks++;
        if (l1s !== 0 || Occupancy !== 5'd0) begin
            errors++;
            $display("FAIL mid_after got active=%0d Occ=%0d want 0 0", l1s, Occupancy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_burst4();
        test_full_and_drop();
        test_read_in_full();
        test_both_and_underflow();
        test_retrigger();
        test_seu();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
